divider_iterative: RTL and testbench
====================================

DIVIDER_ITERATIVE -- requirements
Module: divider_iterative

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; SHALL be legal for 4..32.
REQ-002 Port: clk  in  1  clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  request; sampled at rising clk.
REQ-005 Port: signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: a  in  WIDTH  dividend; sampled with start.
REQ-007 Port: b  in  WIDTH  divisor; sampled with start.
REQ-008 Port: busy  out  1  high while a division is in flight (CALC or FIX state).
REQ-009 Port: valid  out  1  one-cycle pulse marking new result.
REQ-010 Port: div_by_zero  out  1  error flag for the result qualified by valid.
REQ-011 Port: quotient  out  WIDTH  result quotient.
REQ-012 Port: remainder  out  WIDTH  result remainder.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX; valid is a registered pulse, not a state.
REQ-014 start SHALL be accepted only when busy=0, including the cycle valid=1; start while busy=1 SHALL be ignored with no effect on the in-flight operation.
REQ-015 On acceptance: capture signed_op, |a|, |b| (magnitude when signed_op=1, raw when 0), result signs; clear partial remainder and iteration counter; go to CALC.
REQ-016 On acceptance with b=0: no CALC; go directly to FIX with div_by_zero result.
REQ-017 CALC SHALL perform restoring shift-subtract, one quotient bit per cycle, MSB first, exactly WIDTH cycles; partial remainder held WIDTH+1 bits wide.
REQ-018 Counter SHALL be ceil(log2(WIDTH+1)) bits; CALC exits to FIX after iteration WIDTH.
REQ-019 FIX (one cycle) SHALL apply signs: quotient negated if operand signs differ, remainder takes sign of dividend (truncation toward zero); FIX then returns to IDLE.
REQ-020 In the cycle after FIX: valid=1 for exactly one cycle, quotient/remainder/div_by_zero updated simultaneously.
REQ-021 Latency: start accepted at edge k -> valid high after edge k+WIDTH+2 (b!=0); after edge k+2 (b=0).
REQ-022 Divide-by-zero result: quotient = all ones, remainder = a as sampled, div_by_zero=1.
REQ-023 Signed overflow (a = most negative, b = -1, signed_op=1): quotient = most negative value (wrap), remainder = 0, div_by_zero=0.
REQ-024 Unsigned mode SHALL treat all WIDTH bits as magnitude; no sign fix in FIX.
REQ-025 quotient, remainder, div_by_zero SHALL hold last result until the next valid; inputs a/b/signed_op changing during busy SHALL not affect the result.
REQ-026 Back-to-back: start in the valid cycle SHALL be accepted, giving results spaced WIDTH+2 cycles apart.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, busy=0, valid=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
REQ-028 reset mid-CALC SHALL abort the operation; no valid pulse for it after release.
REQ-029 First start SHALL be accepted on the first rising clk with reset=0.

Verification (WIDTH=8)
REQ-030 Unsigned a=200, b=7 -> valid 10 cycles after start edge, quotient=0x1C, remainder=0x04, div_by_zero=0.
REQ-031 Signed a=0xF9 (-7), b=0x02 -> quotient=0xFD (-3), remainder=0xFF (-1); a=0x07, b=0xFE -> quotient=0xFD, remainder=0x01.
REQ-032 a=0x35, b=0 (either mode) -> valid 2 cycles after start, quotient=0xFF, remainder=0x35, div_by_zero=1.
REQ-033 Signed a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, div_by_zero=0.
REQ-034 start held high continuously with changing a/b -> one result per 10 cycles, each matching operands present on its accepting edge; starts during busy ignored.
REQ-035 reset pulsed 4 cycles into CALC -> outputs zero immediately, no valid afterwards until a new start; next division 100/10 -> quotient=0x0A, remainder=0x00.

Source files
------------

// File: rtl/divider_iterative.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned operands.
// Handshake: start is accepted on any rising edge where busy is low; valid pulses once per accepted request.
module divider_iterative #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH:0]   rem_q;
    logic             sgn_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dbz_q;
    logic             pend_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] fix_quo_d;
    logic [WIDTH-1:0] fix_rem_d;

    always_comb begin
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        // dvd_q doubles as the shift-in source for dividend bits and the sink for quotient bits
        rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
        q_bit     = ~diff[WIDTH+1];
        rem_d     = q_bit ? diff[WIDTH:0] : rem_shift;
        dvd_d     = {dvd_q[WIDTH-2:0], q_bit};
        fix_quo_d = (sgn_q & q_neg_q) ? -dvd_q : dvd_q;
        fix_rem_d = (sgn_q & r_neg_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            sgn_q       <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            pend_q      <= 1'b0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            valid  <= 1'b0;
            pend_q <= 1'b0;
            // The FIX result parks in dvd_q/rem_q for one cycle, then publishes with valid
            if (pend_q) begin
                valid       <= 1'b1;
                quotient    <= dvd_q;
                remainder   <= rem_q[WIDTH-1:0];
                div_by_zero <= dbz_q;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sgn_q   <= signed_op;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        dvs_q   <= b_mag;
                        cnt_q   <= '0;
                        if (b == '0) begin
                            dbz_q   <= 1'b1;
                            sgn_q   <= 1'b0;
                            dvd_q   <= '1;
                            rem_q   <= {1'b0, a};
                            state_q <= FIX;
                        end else begin
                            dbz_q   <= 1'b0;
                            dvd_q   <= a_mag;
                            rem_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    dvd_q   <= fix_quo_d;
                    rem_q   <= {1'b0, fix_rem_d};
                    pend_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: arithmetic reference model, per-cycle scoreboard,
// directed literal cases, held-start and randomized traffic, and a mid-operation reset.
module tb_divider_iterative;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         valid;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [1:0]   state_dbg;

    divider_iterative #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid       (valid),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected results {quotient, remainder, div_by_zero} and the edge index they are due after
    logic [2*W:0] exp_q[$];
    int           due_q[$];

    function automatic logic [2*W:0] model(input logic sop, input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int q;
        int r;
        if (y == '0) return {{W{1'b1}}, x, 1'b1};
        if (sop) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'({24'd0, x});
            sy = int'({24'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {W'(q), W'(r), 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: n counts rising edges seen so far
    int           n = 0;
    int           free_edge = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    initial begin
        logic [2*W:0] e;
        logic         exp_v;
        int           lat;
        forever begin
            @(negedge clk);
            n++;
            if (reset) begin
                check("rst_valid", {31'd0, valid}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_quotient", {24'd0, quotient}, 32'd0);
                check("rst_remainder", {24'd0, remainder}, 32'd0);
                check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
                exp_q.delete();
                due_q.delete();
                free_edge = 0;
                last_q = '0;
                last_r = '0;
                last_z = 1'b0;
            end else begin
                exp_v = (due_q.size() > 0) && (due_q[0] == n);
                check("valid", {31'd0, valid}, {31'd0, exp_v});
                if (exp_v) begin
                    e = exp_q.pop_front();
                    void'(due_q.pop_front());
                    last_q = e[2*W:W+1];
                    last_r = e[W:1];
                    last_z = e[0];
                end
                check("quotient", {24'd0, quotient}, {24'd0, last_q});
                check("remainder", {24'd0, remainder}, {24'd0, last_r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, last_z});
                check("busy", {31'd0, busy}, (n < free_edge - 1) ? 32'd1 : 32'd0);
            end
            // Inputs are stable here and are what the next rising edge samples
            if (!reset && start && (n + 1 >= free_edge)) begin
                lat = (b == '0) ? 2 : W + 2;
                exp_q.push_back(model(signed_op, a, b));
                due_q.push_back(n + 1 + lat);
                free_edge = n + 1 + lat;
            end
        end
    end

    task automatic drive(input logic s, input logic sop, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #2;
        start     = s;
        signed_op = sop;
        a         = x;
        b         = y;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) drive(1'b0, 1'($urandom), W'($urandom), W'($urandom));
    endtask

    // Issue one request, scramble operands while it runs, then check the literal result at the due edge
    task automatic directed(input string name, input logic sop, input logic [W-1:0] x, input logic [W-1:0] y,
                            input int lat, input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        idle(W + 3);
        drive(1'b1, sop, x, y);
        idle(lat + 1);
        @(negedge clk);
        check({name, "_valid"}, {31'd0, valid}, 32'd1);
        check({name, "_q"}, {24'd0, quotient}, {24'd0, eq});
        check({name, "_r"}, {24'd0, remainder}, {24'd0, er});
        check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    function automatic logic [W-1:0] pick_operand(input bit divisor);
        case ($urandom_range(0, 7))
            0: return divisor ? W'(0) : W'(8'h80);
            1: return W'(8'hFF);
            2: return W'(8'h80);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // Literal pins on the reference model
        check("pin_200_7", {15'd0, model(1'b0, 8'd200, 8'd7)}, {15'd0, 8'h1C, 8'h04, 1'b0});
        check("pin_m7_2", {15'd0, model(1'b1, 8'hF9, 8'h02)}, {15'd0, 8'hFD, 8'hFF, 1'b0});
        check("pin_7_m2", {15'd0, model(1'b1, 8'h07, 8'hFE)}, {15'd0, 8'hFD, 8'h01, 1'b0});
        check("pin_dbz", {15'd0, model(1'b1, 8'h35, 8'h00)}, {15'd0, 8'hFF, 8'h35, 1'b1});
        check("pin_ovf", {15'd0, model(1'b1, 8'h80, 8'hFF)}, {15'd0, 8'h80, 8'h00, 1'b0});
        check("pin_uns_ff", {15'd0, model(1'b0, 8'h80, 8'hFF)}, {15'd0, 8'h00, 8'h80, 1'b0});

        repeat (2) @(posedge clk);
        // Start presented together with reset release must be taken on the first edge
        #2;
        reset = 1'b0;
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd7;
        idle(W + 3);
        @(negedge clk);
        check("first_valid", {31'd0, valid}, 32'd1);
        check("first_q", {24'd0, quotient}, 32'h1C);
        check("first_r", {24'd0, remainder}, 32'h04);

        directed("uns_200_7", 1'b0, 8'd200, 8'd7, W + 2, 8'h1C, 8'h04, 1'b0);
        directed("sgn_m7_2", 1'b1, 8'hF9, 8'h02, W + 2, 8'hFD, 8'hFF, 1'b0);
        directed("sgn_7_m2", 1'b1, 8'h07, 8'hFE, W + 2, 8'hFD, 8'h01, 1'b0);
        directed("dbz_uns", 1'b0, 8'h35, 8'h00, 2, 8'hFF, 8'h35, 1'b1);
        directed("dbz_sgn", 1'b1, 8'h35, 8'h00, 2, 8'hFF, 8'h35, 1'b1);
        directed("sgn_ovf", 1'b1, 8'h80, 8'hFF, W + 2, 8'h80, 8'h00, 1'b0);
        directed("uns_max", 1'b0, 8'hFF, 8'h01, W + 2, 8'hFF, 8'h00, 1'b0);

        // Abort four cycles into CALC
        idle(W + 3);
        drive(1'b1, 1'b0, 8'd200, 8'd3);
        idle(5);
        reset = 1'b1;
        #1;
        check("abort_q", {24'd0, quotient}, 32'd0);
        check("abort_r", {24'd0, remainder}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        idle(20);
        directed("after_abort", 1'b0, 8'd100, 8'd10, W + 2, 8'h0A, 8'h00, 1'b0);

        // Start held high with operands changing every cycle
        repeat (60) drive(1'b1, 1'($urandom), pick_operand(1'b0), pick_operand(1'b1));

        // Randomized traffic
        repeat (1500) drive($urandom_range(0, 3) != 0, 1'($urandom), pick_operand(1'b0), pick_operand(1'b1));

        idle(W + 4);
        @(negedge clk);
        check("drained", due_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
